// File: rtl/fwft_fifo.sv
// Single-clock show-ahead FIFO with dcfifo-style port names.
// The head word is presented on q combinationally whenever the queue holds
// data, so a consumer sees a valid word with no read latency and pops it by
// asserting rdreq. Read-side and write-side status views are identical
// because both sides share one clock; each count carries an extra MSB so
// the full-depth value (DEPTH) can be represented.
module fwft_fifo #(
  parameter int LOG_DEPTH = 8,
  parameter int WIDTH     = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data,
  input  logic                 wrreq,
  input  logic                 rdreq,
  output logic [WIDTH-1:0]     q,
  output logic                 wrempty,
  output logic                 wrfull,
  output logic                 rdempty,
  output logic                 rdfull,
  output logic [LOG_DEPTH:0]   wrusedw,
  output logic [LOG_DEPTH:0]   rdusedw
);

  localparam int DEPTH = 2 ** LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL_COUNT = (LOG_DEPTH + 1)'(DEPTH);

  // Storage is never reset; stale contents are hidden by the count.
  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wp;
  logic [LOG_DEPTH-1:0] rp;
  logic [LOG_DEPTH:0]   count;

  logic empty;
  logic full;
  logic rd_acc;
  logic wr_acc;

  // Pointer advance wraps naturally modulo DEPTH through the bit width.
  function automatic logic [LOG_DEPTH-1:0] ptr_inc(input logic [LOG_DEPTH-1:0] p);
    return p + 1'b1;
  endfunction

  // Occupancy after one cycle: a simultaneous read and write cancel out.
  function automatic logic [LOG_DEPTH:0] count_next(
    input logic [LOG_DEPTH:0] c,
    input logic               wr,
    input logic               rd
  );
    logic [LOG_DEPTH:0] r;
    r = c;
    if (wr && !rd) r = c + 1'b1;
    else if (rd && !wr) r = c - 1'b1;
    return r;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A read is only honoured when there is a head word. A write is honoured
  // when there is room, or when a same-cycle read frees the slot it needs;
  // when full, wp == rp so the new word lands in the slot being vacated.
  assign rd_acc = rdreq && !empty;
  assign wr_acc = wrreq && (!full || rd_acc);

  // Memory write port; no reset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wp] <= data;
    end
  end

  // Pointer and occupancy state; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wp <= ptr_inc(wp);
      if (rd_acc) rp <= ptr_inc(rp);
      count <= count_next(count, wr_acc, rd_acc);
    end
  end

  // Show-ahead output: head word while non-empty, zero otherwise.
  always_comb begin
    q = '0;
    if (!empty) q = mem[rp];
  end

  assign wrempty = empty;
  assign rdempty = empty;
  assign wrfull  = full;
  assign rdfull  = full;
  assign wrusedw = count;
  assign rdusedw = count;

endmodule

// File: tb/tb_fwft_fifo.sv
// Self-checking bench for fwft_fifo: directed scenarios plus randomized
// traffic, all compared every cycle against a queue-based reference model.
module tb_fwft_fifo;

  localparam int LOG_DEPTH = 8;
  localparam int WIDTH     = 6;
  localparam int DEPTH     = 2 ** LOG_DEPTH;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [WIDTH-1:0]     data;
  logic                 wrreq;
  logic                 rdreq;
  logic [WIDTH-1:0]     q;
  logic                 wrempty;
  logic                 wrfull;
  logic                 rdempty;
  logic                 rdfull;
  logic [LOG_DEPTH:0]   wrusedw;
  logic [LOG_DEPTH:0]   rdusedw;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: a plain queue of words.
  int model[$];

  fwft_fifo #(.LOG_DEPTH(LOG_DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .data(data), .wrreq(wrreq), .rdreq(rdreq),
    .q(q), .wrempty(wrempty), .wrfull(wrfull), .rdempty(rdempty),
    .rdfull(rdfull), .wrusedw(wrusedw), .rdusedw(rdusedw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against what the model says should be visible.
  task automatic check_all(input string tag);
    int sz;
    int hd;
    sz = model.size();
    hd = (sz > 0) ? model[0] : 0;
    chk({tag, ".q"},       int'(q),       hd);
    chk({tag, ".rdempty"}, int'(rdempty), int'(sz == 0));
    chk({tag, ".wrempty"}, int'(wrempty), int'(sz == 0));
    chk({tag, ".rdfull"},  int'(rdfull),  int'(sz == DEPTH));
    chk({tag, ".wrfull"},  int'(wrfull),  int'(sz == DEPTH));
    chk({tag, ".rdusedw"}, int'(rdusedw), sz);
    chk({tag, ".wrusedw"}, int'(wrusedw), sz);
  endtask

  // One clock cycle with the given inputs; model updates from pre-edge state.
  task automatic step(input string tag, input bit rst, input bit wr,
                      input bit rd, input int d);
    bit rd_ok;
    bit wr_ok;
    reset = rst;
    wrreq = wr;
    rdreq = rd;
    data  = WIDTH'(d);
    rd_ok = rd && (model.size() > 0);
    wr_ok = wr && ((model.size() < DEPTH) || rd_ok);
    @(posedge clk);
    if (rst) begin
      model.delete();
    end else begin
      if (rd_ok) void'(model.pop_front());
      if (wr_ok) model.push_back(d % (1 << WIDTH));
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    wrreq = 1'b0;
    rdreq = 1'b0;
    data  = '0;

    // Reset then idle, and a read while empty.
    step("rst", 1, 0, 0, 0);
    step("rst", 1, 0, 0, 0);
    step("idle", 0, 0, 0, 0);
    step("rd_empty", 0, 0, 1, 0);

    // Single word in, single word out.
    step("wr1", 0, 1, 0, 6'b010_100);
    chk("single.q", int'(q), 6'b010_100);
    step("rd1", 0, 0, 1, 0);

    // Order and wrap.
    for (int i = 1; i <= 5; i++) step("ord_wr", 0, 1, 0, i);
    for (int i = 0; i < 3; i++) step("ord_rd", 0, 0, 1, 0);
    for (int i = 6; i <= 256; i++) step("ord_wr2", 0, 1, 0, i);
    while (model.size() > 0) step("ord_drain", 0, 0, 1, 0);

    // Simultaneous read and write while empty: only the write lands.
    step("sim_empty", 0, 1, 1, 33);
    chk("sim_empty.cnt", int'(rdusedw), 1);
    step("sim_empty_rd", 0, 0, 1, 0);

    // Fill to capacity, overflow attempt, simultaneous at full, drain.
    for (int i = 0; i < DEPTH; i++) step("fill", 0, 1, 0, i ^ 21);
    chk("full.flag", int'(wrfull), 1);
    step("overflow", 0, 1, 0, 63);
    step("sim_full", 0, 1, 1, 42);
    chk("sim_full.cnt", int'(wrusedw), DEPTH);
    while (model.size() > 0) step("full_drain", 0, 0, 1, 0);

    // Reset mid-stream, with requests asserted alongside reset.
    for (int i = 0; i < 10; i++) step("pre_rst", 0, 1, 0, 50 + i);
    step("mid_rst", 1, 1, 1, 7);
    chk("mid_rst.empty", int'(rdempty), 1);
    step("post_wr", 0, 1, 0, 19);
    step("post_rd", 0, 0, 1, 0);

    // Randomized traffic in phases biased toward filling and draining.
    for (int ph = 0; ph < 6; ph++) begin
      int wr_pct;
      wr_pct = (ph % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 500; i++) begin
        bit wr;
        bit rd;
        bit rs;
        wr = ($urandom_range(99) < wr_pct);
        rd = ($urandom_range(99) < (100 - wr_pct));
        rs = ($urandom_range(999) == 0);
        step("rand", rs, wr, rd, int'($urandom_range((1 << WIDTH) - 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
